phase_load_sched: RTL
=====================

PHASE_LOAD_SCHED -- requirements
Module: phase_load_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of neuron requesters (2..16).
REQ-002 Parameter SETTLE, default 16, idle cycles after each load before the next grant (>=1).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-neuron phase-load request, level, held until granted.
REQ-006 phase_flat  input  4*N_REQ  neuron i phase code at bits [4i+3:4i].
REQ-007 gnt  output  N_REQ  one-hot grant pulse, one cycle, coincident with load.
REQ-008 sel  output  clog2(N_REQ)  index of the neuron being loaded, valid while load=1, held afterwards.
REQ-009 lb  output  16  phase pattern driven to the shared neuron load bus.
REQ-010 load  output  1  one-cycle load strobe for the selected neuron.
REQ-011 busy  output  1  high in LOAD and SETTLE states.

Function
REQ-012 FSM states SHALL be IDLE, LOAD and SETTLE; the encoding is free.
REQ-013 In IDLE with any req bit high, the block SHALL choose a winner k by round-robin, searching upward from pointer ptr with wrap-around, latch phase k and k, and go to LOAD on the next edge.
REQ-014 In IDLE with req all zero, the block SHALL stay in IDLE with outputs unchanged.
REQ-015 In LOAD (exactly one cycle), the block SHALL assert load=1 and gnt[k]=1, set sel=k and lb=pattern(phase k), set ptr=(k+1) mod N_REQ, load the settle counter with SETTLE-1, and go to SETTLE.
REQ-016 In SETTLE, the counter SHALL decrement each cycle, and the FSM SHALL return to IDLE on the cycle after the counter reads 0 (SETTLE cycles in SETTLE).
REQ-017 Latency: req first seen high in IDLE at edge t SHALL give load=1 in cycle t+1; back-to-back grants SHALL be separated by exactly SETTLE+2 cycles.
REQ-018 pattern(p) for p=0..8 SHALL be 16'hFF00 logically shifted right by p (p=0 gives 16'hFF00, p=8 gives 16'h00FF).
REQ-019 lb SHALL hold its value between loads, and sel SHALL likewise hold.
REQ-020 The phase SHALL be sampled only in the IDLE decision cycle; later changes SHALL NOT affect the in-flight load.
REQ-021 A req deasserted before its grant SHALL be ignored, with no grant and no ptr change.
REQ-022 req bits arriving during LOAD/SETTLE SHALL wait and be arbitrated in the next IDLE cycle.
REQ-023 gnt SHALL be zero in all cycles where load=0.

Reset
REQ-024 On rst high, the block SHALL immediately go to IDLE with load=0, gnt=0, busy=0, sel=0, lb=16'hFF00, ptr=0 and counter=0, including mid-LOAD or mid-SETTLE.
REQ-025 After rst deasserts, the first arbitration SHALL start from index 0, with no load emitted during or because of reset.

Configuration
REQ-026 The macro PHASE_CLAMP_EN SHALL control out-of-range phase codes (9..15).
REQ-027 With PHASE_CLAMP_EN defined, a phase code of 9..15 SHALL be clamped to 8 (lb=16'h00FF).
REQ-028 Without PHASE_CLAMP_EN, a phase code of 9..15 SHALL give lb=16'hFF00 (phase-0 pattern).
REQ-029 In both configurations, an out-of-range phase code SHALL still produce a normal grant and load.

Verification
REQ-030 Reset then req=4'b0001, phase0=3 -> next cycle load=1, gnt=0001, sel=0, lb=16'h1FE0; busy for 17 cycles (SETTLE=16).
REQ-031 req=4'b1111 held, phases 0,2,5,8 -> grants in order 0,1,2,3,0, with lb FF00,3FC0,07F8,00FF,FF00, each load 18 cycles apart.
REQ-032 Grant to 2 then req=4'b1001 -> next grant to 3, then 0 (wrap-around).
REQ-033 phase0=4'hB -> lb=16'h00FF with PHASE_CLAMP_EN, 16'hFF00 without.
REQ-034 rst asserted 5 cycles into SETTLE -> busy=0 and load=0 at once, lb=16'hFF00, and the next grant goes to the lowest requesting index.
REQ-035 phase1 changed from 2 to 7 during the LOAD cycle -> lb=16'h3FC0 for that load.

Source files
------------

// File: rtl/phase_load_sched.sv
// -----------------------------------------------------------------------------
// phase_load_sched
//
// Round-robin scheduler that hands a shared 16-bit neuron load bus to one of
// N_REQ requesting neurons at a time. Each grant is a single LOAD cycle that
// drives the selected neuron's phase pattern onto lb, followed by SETTLE idle
// cycles so the loaded neuron can settle before the bus is reused.
//
// Parameters
//   N_REQ   number of requesting neurons (2..16)
//   SETTLE  idle cycles after each load before the next grant (>= 1)
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous, active-high reset
//   req         per-neuron load request (level, held until granted)
//   phase_flat  neuron i phase code at bits [4i+3:4i]
//   gnt         one-hot grant, high only during the load cycle
//   sel         index of the neuron being loaded; holds between loads
//   lb          phase pattern on the shared load bus; holds between loads
//   load        one-cycle load strobe
//   busy        high while loading or settling
//
// Build option
//   PHASE_CLAMP_EN  when defined, phase codes 9..15 are clamped to 8
//                   (lb = 16'h00FF); otherwise they produce the phase-0
//                   pattern (lb = 16'hFF00). Either way the grant and load
//                   happen normally.
// -----------------------------------------------------------------------------
module phase_load_sched #(
  parameter int N_REQ  = 4,
  parameter int SETTLE = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [4*N_REQ-1:0]       phase_flat,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic [15:0]              lb,
  output logic                     load,
  output logic                     busy
);

  localparam int SW = $clog2(N_REQ);
  // Wide enough to hold SETTLE-1 even when SETTLE is 1.
  localparam int CW = $clog2(SETTLE + 1);

  localparam logic [15:0] LB_RESET = 16'hFF00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   ptr;        // round-robin search start
  logic [SW-1:0]   sel_q;      // winner latched at the decision cycle
  logic [15:0]     lb_q;       // pattern latched at the decision cycle
  logic [CW-1:0]   cnt;        // settle countdown

  logic            win_found;
  logic [SW-1:0]   win_idx;
  logic [3:0]      win_phase;
  int              cand;

  // Phase code -> load-bus pattern. Codes 0..8 slide the 8-bit window from
  // the upper byte to the lower byte; out-of-range codes depend on the build.
  function automatic logic [15:0] pattern(input logic [3:0] p);
    logic [3:0] eff;
`ifdef PHASE_CLAMP_EN
    eff = (p > 4'd8) ? 4'd8 : p;
`else
    eff = (p > 4'd8) ? 4'd0 : p;
`endif
    return 16'hFF00 >> eff;
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requesting index at or above ptr, wrapping.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin : rr_pick
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = SW'(cand);
      end
    end
  end

  assign win_phase = phase_flat[4*win_idx +: 4];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (win_found) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SETTLE;
      // Leave on the edge that ends the cycle in which the counter reads 0,
      // giving exactly SETTLE cycles in this state.
      S_SETTLE: if (cnt == '0) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin : fsm_outputs
    load = (state == S_LOAD);
    busy = (state != S_IDLE);
    gnt  = '0;
    if (load) gnt[sel_q] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Datapath: winner/pattern capture, pointer advance, settle countdown.
  // The phase is captured only at the IDLE decision edge, so later phase
  // changes cannot disturb a load already in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin : datapath
    if (rst) begin
      sel_q <= '0;
      lb_q  <= LB_RESET;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win_found) begin
            sel_q <= win_idx;
            lb_q  <= pattern(win_phase);
          end
        end
        S_LOAD: begin
          ptr <= (sel_q == SW'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
          cnt <= CW'(SETTLE - 1);
        end
        S_SETTLE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sel = sel_q;
  assign lb  = lb_q;

endmodule
